pixel_stream_receiver: RTL and testbench

PIXEL_STREAM_RECEIVER -- requirements
Module: pixel_stream_receiver

---
 rtl/pixel_stream_pkg.sv | 26 ++
 rtl/frame_position_counter.sv | 63 ++++++
 rtl/pixel_stream_receiver.sv | 144 ++++++++++++++
 tb/tb_pixel_stream_receiver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared constants for the pixel stream receiver and the pixel generator.
// Holds frame geometry defaults, FSM state encoding and err_flags bit positions.
// Optional feature macro used by the receiver top: RX_BACKPRESSURE_EN.
package pixel_stream_pkg;

    // Default frame geometry
    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;

    // FSM state encoding
    localparam logic [0:0] ST_WAIT_SOF = 1'b0;
    localparam logic [0:0] ST_RECV     = 1'b1;

    // err_flags bit indices
    localparam int ERR_EARLY_SOF   = 0;
    localparam int ERR_EARLY_EOF   = 1;
    localparam int ERR_MISSING_EOF = 2;
    localparam int ERR_BAD_KEEP    = 3;
    localparam int ERR_W           = 4;

    // Counter width for a range of n values, never below one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_position_counter.sv
// Tracks the (x,y) position of the next expected pixel within a frame.
// Latency: position and flags update on the edge after sof/adv/clr; flags are registered-state decodes.
// Backpressure: none; it only moves when the caller signals an accepted beat.
module frame_position_counter
    import pixel_stream_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sof_i,      // accepted beat is pixel (0,0)
    input  logic adv_i,      // accepted beat is at the current position
    input  logic clr_i,      // frame ended or aborted: back to origin
    output logic last_x_o,
    output logic last_y_o,
    output logic first_o
);

    localparam int XW = cnt_w(X_SIZE);
    localparam int YW = cnt_w(Y_SIZE);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [XW-1:0] x_q, x_d, base_x;
    logic [YW-1:0] y_q, y_d, base_y;

    // Step from the beat's position (origin for an SOF beat) to the next one
    always_comb begin
        base_x = sof_i ? '0 : x_q;
        base_y = sof_i ? '0 : y_q;
        x_d    = x_q;
        y_d    = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (sof_i || adv_i) begin
            if (base_x == X_LAST) begin
                x_d = '0;
                y_d = (base_y == Y_LAST) ? '0 : base_y + YW'(1);
            end else begin
                x_d = base_x + XW'(1);
                y_d = base_y;
            end
        end
    end

    // Position registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign last_x_o = (x_q == X_LAST);
    assign last_y_o = (y_q == Y_LAST);
    assign first_o  = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/pixel_stream_receiver.sv
// AXI-Stream video sink: frames pixels by SOF/EOF, checksums each frame, counts frames/drops, flags errors.
// Latency: frame_done/frame_checksum/frame_count valid 1 cycle after the final handshake.
// Backpressure: tready high out of reset; with RX_BACKPRESSURE_EN it drops one cycle in every four.
module pixel_stream_receiver
    import pixel_stream_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic             in_stream_aclk,
    input  logic             periph_resetn,
    input  logic [31:0]      in_stream_tdata,
    input  logic [3:0]       in_stream_tkeep,
    input  logic             in_stream_tlast,
    input  logic             in_stream_tuser,
    input  logic             in_stream_tvalid,
    output logic             in_stream_tready,
    input  logic             clear_errors,
    output logic             frame_done,
    output logic [31:0]      frame_checksum,
    output logic [15:0]      frame_count,
    output logic [15:0]      drop_count,
    output logic [ERR_W-1:0] err_flags
);

    // A one-pixel frame completes on its SOF beat
    localparam logic ONE_PIX = (X_SIZE * Y_SIZE == 1);

    logic             rdy;
    logic             hs;
    logic [0:0]       state_q, state_d;
    logic [31:0]      sum_q, sum_d, pix_sum;
    logic [31:0]      cks_q;
    logic [15:0]      fcnt_q;
    logic [15:0]      drop_q, drop_d;
    logic [ERR_W-1:0] err_q, new_err;
    logic             done_q;
    logic             complete, abort;
    logic             pos_sof, pos_adv, pos_clr;
    logic             last_x, last_y, first;
    logic             is_last_pos;

`ifdef RX_BACKPRESSURE_EN
    logic [1:0] bp_cnt_q;

    // Free-running phase counter; tready drops when it reads 3
    always_ff @(posedge in_stream_aclk) begin
        if (!periph_resetn) bp_cnt_q <= 2'd0;
        else                bp_cnt_q <= bp_cnt_q + 2'd1;
    end

    assign rdy = periph_resetn & (bp_cnt_q != 2'd3);
`else
    assign rdy = periph_resetn;
`endif

    assign in_stream_tready = rdy;
    assign hs               = in_stream_tvalid & rdy;

    frame_position_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_pos (
        .clk_i    (in_stream_aclk),
        .rst_n_i  (periph_resetn),
        .sof_i    (pos_sof),
        .adv_i    (pos_adv),
        .clr_i    (pos_clr),
        .last_x_o (last_x),
        .last_y_o (last_y),
        .first_o  (first)
    );

    // A restart taken mid-frame sits at the origin, not at the counter's position
    assign is_last_pos = (in_stream_tuser && !first) ? ONE_PIX : (last_x & last_y);

    // Per-beat decision: drop, start, continue, complete or abort
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        pix_sum  = '0;
        drop_d   = drop_q;
        new_err  = '0;
        complete = 1'b0;
        abort    = 1'b0;
        pos_sof  = 1'b0;
        pos_adv  = 1'b0;
        if (hs) begin
            if (in_stream_tkeep != 4'b1111) new_err[ERR_BAD_KEEP] = 1'b1;
            if (state_q == ST_WAIT_SOF && !in_stream_tuser) begin
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end else begin
                pix_sum = in_stream_tuser ? in_stream_tdata : sum_q + in_stream_tdata;
                sum_d   = pix_sum;
                pos_sof = in_stream_tuser;
                pos_adv = ~in_stream_tuser;
                if (state_q == ST_RECV && in_stream_tuser) new_err[ERR_EARLY_SOF] = 1'b1;
                if (in_stream_tlast && !is_last_pos) begin
                    new_err[ERR_EARLY_EOF] = 1'b1;
                    abort   = 1'b1;
                    state_d = ST_WAIT_SOF;
                end else if (is_last_pos) begin
                    if (!in_stream_tlast) new_err[ERR_MISSING_EOF] = 1'b1;
                    complete = 1'b1;
                    state_d  = ST_WAIT_SOF;
                end else begin
                    state_d = ST_RECV;
                end
            end
        end
    end

    assign pos_clr = complete | abort;

    // State, accumulator, counters and sticky error flags
    always_ff @(posedge in_stream_aclk) begin
        if (!periph_resetn) begin
            state_q <= ST_WAIT_SOF;
            sum_q   <= '0;
            cks_q   <= '0;
            fcnt_q  <= '0;
            drop_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            drop_q  <= drop_d;
            err_q   <= (clear_errors ? '0 : err_q) | new_err;
            done_q  <= complete;
            if (complete) begin
                cks_q  <= pix_sum;
                fcnt_q <= fcnt_q + 16'd1;
            end
        end
    end

    assign frame_done     = done_q;
    assign frame_checksum = cks_q;
    assign frame_count    = fcnt_q;
    assign drop_count     = drop_q;
    assign err_flags      = err_q;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Directed bench for pixel_stream_receiver with a 4x2 frame.
// Table of beats with hand-computed expected status, plus a reset/backpressure sequence.
// Works with or without RX_BACKPRESSURE_EN: every beat waits for tready.
module tb_pixel_stream_receiver;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tuser, tvalid, tready, clr;
    logic        done;
    logic [31:0] cks;
    logic [15:0] fcnt, dcnt;
    logic [3:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_stream_receiver #(.X_SIZE(4), .Y_SIZE(2)) dut (
        .in_stream_aclk   (clk),
        .periph_resetn    (resetn),
        .in_stream_tdata  (tdata),
        .in_stream_tkeep  (tkeep),
        .in_stream_tlast  (tlast),
        .in_stream_tuser  (tuser),
        .in_stream_tvalid (tvalid),
        .in_stream_tready (tready),
        .clear_errors     (clr),
        .frame_done       (done),
        .frame_checksum   (cks),
        .frame_count      (fcnt),
        .drop_count       (dcnt),
        .err_flags        (err)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l, u, v, c;
        logic        e_done;
        logic [31:0] e_ck;
        logic [15:0] e_fc, e_dc;
        logic [3:0]  e_er;
    } vec_t;

    vec_t tbl[$];

    function automatic void row(input logic [31:0] d, input logic [3:0] k, input logic l, u, v, c,
                                input logic e_done, input logic [31:0] e_ck,
                                input logic [15:0] e_fc, e_dc, input logic [3:0] e_er);
        vec_t r;
        r.d = d; r.k = k; r.l = l; r.u = u; r.v = v; r.c = c;
        r.e_done = e_done; r.e_ck = e_ck; r.e_fc = e_fc; r.e_dc = e_dc; r.e_er = e_er;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (tready !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 8) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout got %b expected 1", tready);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l, u, v, c);
        tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = v; clr = c;
        wait_rdy();
        @(posedge clk); #1;
    endtask

    task automatic clean_frame();
        for (int i = 0; i < 8; i++)
            drive(32'(i), 4'hF, i == 7, i == 0, 1'b1, 1'b0);
        tvalid = 1'b0;
    endtask

    initial begin
        logic exp_rdy;
        int   exp_drop;

        resetn = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 0; tuser = 0; tvalid = 0; clr = 0;

        // Clean frame 0..7
        for (int i = 0; i < 7; i++) row(i, 4'hF, 0, i == 0, 1, 0, 0, 0, 0, 0, 4'b0000);
        row(7, 4'hF, 1, 0, 1, 0, 1, 32'h1C, 1, 0, 4'b0000);
        row(0, 4'hF, 0, 0, 0, 0, 0, 32'h1C, 1, 0, 4'b0000);
        // tvalid low with junk sideband: no effect
        row(32'hDEAD, 4'h0, 1, 1, 0, 0, 0, 32'h1C, 1, 0, 4'b0000);
        // Preamble of 3 dropped beats, then a clean frame
        for (int i = 0; i < 3; i++) row(32'h55, 4'hF, 0, 0, 1, 0, 0, 32'h1C, 1, 16'(i + 1), 4'b0000);
        for (int i = 0; i < 7; i++) row(i, 4'hF, 0, i == 0, 1, 0, 0, 32'h1C, 1, 3, 4'b0000);
        row(7, 4'hF, 1, 0, 1, 0, 1, 32'h1C, 2, 3, 4'b0000);
        // tlast on beat 5: early_eof, no done
        for (int i = 0; i < 5; i++) row(i, 4'hF, 0, i == 0, 1, 0, 0, 32'h1C, 2, 3, 4'b0000);
        row(5, 4'hF, 1, 0, 1, 0, 0, 32'h1C, 2, 3, 4'b0010);
        row(0, 4'hF, 0, 0, 0, 0, 0, 32'h1C, 2, 3, 4'b0010);
        for (int i = 0; i < 7; i++) row(i, 4'hF, 0, i == 0, 1, 0, 0, 32'h1C, 2, 3, 4'b0010);
        row(7, 4'hF, 1, 0, 1, 0, 1, 32'h1C, 3, 3, 4'b0010);
        row(0, 4'hF, 0, 0, 0, 1, 0, 32'h1C, 3, 3, 4'b0000);
        // SOF on beat 3 restarts the frame with 10..17
        for (int i = 0; i < 3; i++) row(i, 4'hF, 0, i == 0, 1, 0, 0, 32'h1C, 3, 3, 4'b0000);
        row(10, 4'hF, 0, 1, 1, 0, 0, 32'h1C, 3, 3, 4'b0001);
        for (int i = 11; i < 17; i++) row(i, 4'hF, 0, 0, 1, 0, 0, 32'h1C, 3, 3, 4'b0001);
        row(17, 4'hF, 1, 0, 1, 0, 1, 32'h6C, 4, 3, 4'b0001);
        row(0, 4'hF, 0, 0, 0, 1, 0, 32'h6C, 4, 3, 4'b0000);
        // Last beat without tlast and with partial keep
        for (int i = 0; i < 7; i++) row(i, 4'hF, 0, i == 0, 1, 0, 0, 32'h6C, 4, 3, 4'b0000);
        row(7, 4'b0111, 0, 0, 1, 0, 1, 32'h1C, 5, 3, 4'b1100);
        row(0, 4'hF, 0, 0, 0, 1, 0, 32'h1C, 5, 3, 4'b0000);
        // SOF+EOF in WAIT_SOF aborts; the next plain beat is dropped
        row(9, 4'hF, 1, 1, 1, 0, 0, 32'h1C, 5, 3, 4'b0010);
        row(1, 4'hF, 0, 0, 1, 0, 0, 32'h1C, 5, 4, 4'b0010);
        // Clear in the same cycle as a new bad_keep error keeps the new error
        row(2, 4'b0011, 0, 0, 1, 1, 0, 32'h1C, 5, 5, 4'b1000);
        row(0, 4'hF, 0, 0, 0, 1, 0, 32'h1C, 5, 5, 4'b0000);
        // SOF+EOF in RECV: early_sof and early_eof, then back to WAIT_SOF
        row(0, 4'hF, 0, 1, 1, 0, 0, 32'h1C, 5, 5, 4'b0000);
        row(3, 4'hF, 1, 1, 1, 0, 0, 32'h1C, 5, 5, 4'b0011);
        row(4, 4'hF, 0, 0, 1, 0, 0, 32'h1C, 5, 6, 4'b0011);

        // Reset values
        @(posedge clk); #1;
        chk("rst_tready", tready, 0);
        chk("rst_done", done, 0);
        chk("rst_cks", cks, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_drop", dcnt, 0);
        chk("rst_err", err, 0);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].u, tbl[i].v, tbl[i].c);
            chk($sformatf("row%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("row%0d_cks", i), cks, tbl[i].e_ck);
            chk($sformatf("row%0d_fcnt", i), fcnt, tbl[i].e_fc);
            chk($sformatf("row%0d_drop", i), dcnt, tbl[i].e_dc);
            chk($sformatf("row%0d_err", i), err, tbl[i].e_er);
        end
        tvalid = 1'b0; clr = 1'b0;

        // Reset asserted at beat 4 of a frame
        for (int i = 0; i < 4; i++) drive(32'(i), 4'hF, 0, i == 0, 1'b1, 1'b0);
        tdata = 32'd4; tuser = 1'b0; tvalid = 1'b1; resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_tready", tready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cks", cks, 0);
        chk("midrst_fcnt", fcnt, 0);
        chk("midrst_err", err, 0);

        // tvalid held high after reset: tready pattern, no done
        tdata = '0; tkeep = 4'hF; tlast = 0; tuser = 0; resetn = 1'b1;
        exp_drop = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef RX_BACKPRESSURE_EN
            exp_rdy = (i % 4) != 3;
`else
            exp_rdy = 1'b1;
`endif
            if (exp_rdy) exp_drop++;
            chk($sformatf("bp%0d_tready", i), tready, exp_rdy);
            chk($sformatf("bp%0d_done", i), done, 0);
            @(posedge clk); #1;
        end
        chk("bp_drop", dcnt, 32'(exp_drop));
        chk("bp_err", err, 0);
        tvalid = 1'b0;

        // Clean frame after reset
        clean_frame();
        chk("post_done", done, 1);
        chk("post_cks", cks, 32'h1C);
        chk("post_fcnt", fcnt, 1);
        chk("post_err", err, 0);
        @(posedge clk); #1;
        chk("post_done_pulse", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
